// File: rtl/walk_pkg.sv
// Shared types and defaults for the multi-channel crosswalk request bank.
package walk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SERVE = 2'd2
  } walk_state_e;

  localparam int NUM_CH_DEF       = 4;
  localparam int DEBOUNCE_DEF     = 3;
  localparam int WAIT_W_DEF       = 8;
  localparam int URGENT_LIMIT_DEF = 200;

  // Channel index width; a two-channel bank still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/walk_debounce.sv
// One crosswalk button: 2-flop synchroniser, run-length debounce and a
// single-cycle press event that will not repeat while the button is held.
module walk_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count parks at CNT_TOP while held, so the event fires only once per press.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press_o = sync2_q && (cnt_q == CNT_ARM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/walk_request_bank.sv
// Latches debounced walk requests per crosswalk, ages them, and offers one
// channel at a time to the traffic controller (urgent-first round-robin).
module walk_request_bank
  import walk_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int WAIT_W       = WAIT_W_DEF,
  parameter int URGENT_LIMIT = URGENT_LIMIT_DEF,
  localparam int IDX_W       = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              sys_reset,
  input  logic [NUM_CH-1:0] walk_req_in,
  input  logic [NUM_CH-1:0] clear_in,
  input  logic              grant_ready,
  input  logic              grant_done,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] urgent,
  output logic              any_pending
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;
  localparam logic [WAIT_W-1:0] URG_LIM  = WAIT_W'(URGENT_LIMIT);

  walk_state_e       state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] press;
  logic [WAIT_W-1:0] wait_q [NUM_CH];
  logic [WAIT_W-1:0] wait_d [NUM_CH];
  logic              gvalid_q, gvalid_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              serving;

  // First set bit of mask after 'last', wrapping around the channels.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                               input logic [IDX_W-1:0]  last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               j;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = (int'(last) + k) % NUM_CH;
      if (!found && mask[j]) begin
        pick  = IDX_W'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    walk_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk     (clk),
      .rst     (sys_reset),
      .btn_i   (walk_req_in[g]),
      .press_o (press[g])
    );
  end

  assign serving = (state_q == SERVE);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pending_d[i] = pending_q[i];
      if (clear_in[i]) begin
        pending_d[i] = 1'b0;
      end else if (serving && grant_done && (gidx_q == IDX_W'(i))) begin
        pending_d[i] = 1'b0;
      end else if (press[i] && !(serving && (gidx_q == IDX_W'(i)))) begin
        pending_d[i] = 1'b1;
      end
      // Age restarts from zero whenever a request is freshly latched or dropped.
      wait_d[i] = '0;
      if (pending_d[i] && pending_q[i]) begin
        wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
      end
      urgent[i] = pending_q[i] && (wait_q[i] >= URG_LIM);
    end
  end

  always_comb begin
    state_d  = state_q;
    gvalid_d = gvalid_q;
    gidx_d   = gidx_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          gidx_d   = rr_pick((|urgent) ? urgent : pending_q, last_q);
          gvalid_d = 1'b1;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        // Ready beats a same-cycle clear: the controller has already committed.
        if (grant_ready) begin
          gvalid_d = 1'b0;
          state_d  = SERVE;
        end else if (clear_in[gidx_q]) begin
          gvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      SERVE: begin
        if (grant_done) begin
          last_d  = gidx_q;
          state_d = IDLE;
        end
      end
      default: begin
        gvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gvalid_q  <= 1'b0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gvalid_q  <= gvalid_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      for (int i = 0; i < NUM_CH; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign grant_valid = gvalid_q;
  assign grant_idx   = gidx_q;
  assign pending     = pending_q;
  assign any_pending = |pending_q;

endmodule

// File: tb/tb_walk_request_bank.sv
// Bench for walk_request_bank: directed scenarios plus random traffic, all
// checked every cycle against a sample-history / timestamp reference model.
module tb_walk_request_bank;

  localparam int N    = 4;
  localparam int DB   = 3;
  localparam int WW   = 4;
  localparam int UL   = 10;
  localparam int SATV = (1 << WW) - 1;

  logic         clk = 1'b0;
  logic         sys_reset;
  logic [N-1:0] walk_req_in;
  logic [N-1:0] clear_in;
  logic         grant_ready;
  logic         grant_done;
  logic         grant_valid;
  logic [1:0]   grant_idx;
  logic [N-1:0] pending;
  logic [N-1:0] urgent;
  logic         any_pending;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [N-1:0] m_pend;
  int           m_set [N];
  int           m_phase;   // 0 idle, 1 offering, 2 serving
  int           m_gidx;
  int           m_last;
  logic         m_gv;
  int           ecount = 0;
  bit           hist [N][$];

  walk_request_bank #(
    .NUM_CH(N), .DEBOUNCE(DB), .WAIT_W(WW), .URGENT_LIMIT(UL)
  ) dut (
    .clk         (clk),
    .sys_reset   (sys_reset),
    .walk_req_in (walk_req_in),
    .clear_in    (clear_in),
    .grant_ready (grant_ready),
    .grant_done  (grant_done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .pending     (pending),
    .urgent      (urgent),
    .any_pending (any_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 'h%0h, expected 'h%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_urg(input int at);
    logic [N-1:0] u;
    u = '0;
    for (int i = 0; i < N; i++) begin
      int age;
      age = at - m_set[i];
      if (age > SATV) age = SATV;
      u[i] = m_pend[i] && (age >= UL);
    end
    return u;
  endfunction

  function automatic int m_pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (mask[j]) return j;
    end
    return 0;
  endfunction

  // A press lands at edge e when the raw samples taken at edges e-2 .. e-1-DB
  // were all high and the one before them was low (or predates reset).
  function automatic bit m_event(input int i);
    int n;
    n = hist[i].size();
    for (int j = 0; j < DB; j++) begin
      int idx;
      idx = n - 3 - j;
      if (idx < 0) return 1'b0;
      if (!hist[i][idx]) return 1'b0;
    end
    if ((n - 3 - DB) >= 0 && hist[i][n - 3 - DB]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_phase = 0;
    m_gv    = 1'b0;
    m_gidx  = 0;
    m_last  = N - 1;
    for (int i = 0; i < N; i++) begin
      m_set[i] = 0;
      hist[i].delete();
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] pre_pend;
    logic [N-1:0] pre_urg;
    int           old_phase;
    ecount++;
    if (sys_reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) hist[i].push_back(walk_req_in[i]);
    pre_pend  = m_pend;
    pre_urg   = m_urg(ecount - 1);
    old_phase = m_phase;
    for (int i = 0; i < N; i++) begin
      bit np;
      np = m_pend[i];
      if (clear_in[i]) np = 1'b0;
      else if (old_phase == 2 && grant_done && m_gidx == i) np = 1'b0;
      else if (m_event(i) && !(old_phase == 2 && m_gidx == i)) np = 1'b1;
      if (np && !m_pend[i]) m_set[i] = ecount;
      m_pend[i] = np;
    end
    case (old_phase)
      0: if (|pre_pend) begin
        m_gidx  = m_pick((|pre_urg) ? pre_urg : pre_pend, m_last);
        m_gv    = 1'b1;
        m_phase = 1;
      end
      1: if (grant_ready) begin
        m_gv    = 1'b0;
        m_phase = 2;
      end else if (clear_in[m_gidx]) begin
        m_gv    = 1'b0;
        m_phase = 0;
      end
      default: if (grant_done) begin
        m_last  = m_gidx;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("grant_valid", 32'(grant_valid), 32'(m_gv));
    check_eq("grant_idx",   32'(grant_idx),   32'(m_gidx));
    check_eq("pending",     32'(pending),     32'(m_pend));
    check_eq("urgent",      32'(urgent),      32'(m_urg(ecount)));
    check_eq("any_pending", 32'(any_pending), 32'(|m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    sys_reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_gv",   32'(grant_valid), 32'(0));
    check_eq("arst_pend", 32'(pending),     32'(0));
    compare_all();
    step();
    step();
    sys_reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    walk_req_in = '0;
    clear_in    = '0;
    grant_ready = 1'b1;
    grant_done  = 1'b1;
    k = 0;
    while (k < 100 && (any_pending || grant_valid)) begin
      step();
      k++;
    end
    repeat (3) step();
    check_eq("drain_anyp", 32'(any_pending), 32'(0));
    check_eq("drain_gv",   32'(grant_valid), 32'(0));
    grant_ready = 1'b0;
    grant_done  = 1'b0;
  endtask

  initial begin
    int      grants[$];
    int      cd;
    logic    prev_gv;
    int      exp_seq [3];

    sys_reset   = 1'b1;
    walk_req_in = '1;
    clear_in    = '0;
    grant_ready = 1'b0;
    grant_done  = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    check_eq("rst_pend", 32'(pending), 32'(0));
    check_eq("rst_gv",   32'(grant_valid), 32'(0));
    walk_req_in = '0;
    sys_reset   = 1'b0;
    repeat (4) step();

    // Short pulse rejected, held press accepted on the fifth edge
    walk_req_in[1] = 1'b1;
    repeat (2) step();
    walk_req_in[1] = 1'b0;
    repeat (8) step();
    check_eq("pulse_pend1", 32'(pending[1]), 32'(0));
    walk_req_in[1] = 1'b1;
    repeat (4) step();
    check_eq("hold_e4_pend1", 32'(pending[1]), 32'(0));
    step();
    check_eq("hold_e5_pend1", 32'(pending[1]), 32'(1));
    step();
    walk_req_in[1] = 1'b0;
    repeat (3) step();

    // Clear beats press; no re-arm until release
    clear_in[0]    = 1'b1;
    walk_req_in[0] = 1'b1;
    repeat (7) step();
    check_eq("clr_pend0", 32'(pending[0]), 32'(0));
    clear_in[0] = 1'b0;
    repeat (6) step();
    check_eq("held_pend0", 32'(pending[0]), 32'(0));
    walk_req_in[0] = 1'b0;
    repeat (3) step();
    walk_req_in[0] = 1'b1;
    repeat (5) step();
    check_eq("repress_pend0", 32'(pending[0]), 32'(1));
    drain();

    // Reset in the middle of serving channel 2
    grant_ready    = 1'b1;
    walk_req_in[2] = 1'b1;
    repeat (8) step();
    walk_req_in[2] = 1'b0;
    step();
    check_eq("serve2_pend", 32'(pending[2]), 32'(1));
    async_reset();
    repeat (3) step();

    // Simultaneous presses served in round-robin order
    exp_seq = '{0, 2, 3};
    walk_req_in = 4'b1101;
    grant_ready = 1'b1;
    cd = -1;
    prev_gv = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c == 6) walk_req_in = '0;
      grant_done = (cd == 0);
      step();
      if (cd >= 0) cd--;
      if (grant_valid && !prev_gv) begin
        grants.push_back(int'(grant_idx));
        cd = 4;
      end
      prev_gv = grant_valid;
    end
    grant_done = 1'b0;
    for (int k = 0; k < 3; k++)
      check_eq("rr_seq", (k < grants.size()) ? 32'(grants[k]) : 32'hF, 32'(exp_seq[k]));
    check_eq("rr_pend", 32'(pending), 32'(0));
    check_eq("rr_anyp", 32'(any_pending), 32'(0));

    // Urgent channels take precedence, ages saturate
    walk_req_in = 4'b0010;
    repeat (6) step();
    walk_req_in = 4'b1000;
    repeat (5) step();
    walk_req_in = 4'b0000;
    step();
    walk_req_in = 4'b0001;
    repeat (5) step();
    walk_req_in = 4'b0000;
    repeat (20) step();
    check_eq("urg_03", 32'(urgent & 4'b1001), 32'(4'b1001));
    repeat (10) step();
    check_eq("urg_sat", 32'(urgent & 4'b1001), 32'(4'b1001));
    grant_done = 1'b1;
    step();
    grant_done = 1'b0;
    check_eq("urg_after", 32'(urgent), 32'(4'b1001));
    step();
    check_eq("urg_next_gv",  32'(grant_valid), 32'(1));
    check_eq("urg_next_idx", 32'(grant_idx),   32'(3));
    drain();

    // Withdrawal on clear, and ready winning over clear
    walk_req_in = 4'b0100;
    for (int c = 0; c < 20 && !grant_valid; c++) step();
    check_eq("wd_g2_gv",  32'(grant_valid), 32'(1));
    check_eq("wd_g2_idx", 32'(grant_idx),   32'(2));
    walk_req_in = 4'b0101;
    repeat (6) step();
    walk_req_in = 4'b0000;
    clear_in    = 4'b0100;
    step();
    clear_in = '0;
    check_eq("wd_gv", 32'(grant_valid), 32'(0));
    step();
    check_eq("wd_next_gv",  32'(grant_valid), 32'(1));
    check_eq("wd_next_idx", 32'(grant_idx),   32'(0));
    grant_ready = 1'b1;
    clear_in    = 4'b0001;
    step();
    grant_ready = 1'b0;
    clear_in    = '0;
    check_eq("rc_gv", 32'(grant_valid), 32'(0));
    walk_req_in = 4'b0010;
    repeat (7) step();
    walk_req_in = '0;
    check_eq("rc_serve_gv", 32'(grant_valid), 32'(0));
    grant_done = 1'b1;
    step();
    grant_done = 1'b0;
    step();
    check_eq("rc_next_gv",  32'(grant_valid), 32'(1));
    check_eq("rc_next_idx", 32'(grant_idx),   32'(1));
    drain();

    // Random traffic
    walk_req_in = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) walk_req_in[i] = ~walk_req_in[i];
        clear_in[i] = ($urandom_range(0, 31) == 0);
      end
      grant_ready = ($urandom_range(0, 2) == 0);
      grant_done  = ($urandom_range(0, 3) == 0);
      if (c == 700) async_reset();
      else step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/walk_request_bank.md
Name: walk_request_bank

Overview:
Multi-channel successor to the single walk request latch. It captures debounced pedestrian button presses on NUM_CH crosswalks, holds each one as a sticky pending flag, and tracks how long each has waited. It then hands one channel at a time to the main traffic controller through a grant/ready/done handshake. Selection is round-robin, with priority given to channels that have waited too long ("urgent").

Parameters:
NUM_CH, 4, number of crosswalk channels (2..16)
DEBOUNCE, 3, consecutive synchronised-high cycles needed to accept a press (>=1)
WAIT_W, 8, width of each per-channel wait counter
URGENT_LIMIT, 200, wait count at or above which a pending channel is urgent (< 2^WAIT_W)

Ports:
clk  in  1  system clock, rising edge
sys_reset  in  1  asynchronous, active-high reset
walk_req_in  in  NUM_CH  raw button levels, asynchronous to clk
clear_in  in  NUM_CH  synchronous per-channel clear of pending (replaces walkRegister_reset)
grant_ready  in  1  controller can start a walk phase
grant_done  in  1  one-cycle pulse: granted walk phase finished
grant_valid  out  1  a grant is offered
grant_idx  out  clog2(NUM_CH)  granted channel; stable while grant_valid or in SERVE
pending  out  NUM_CH  latched requests
urgent  out  NUM_CH  pending[i] and wait[i] >= URGENT_LIMIT
any_pending  out  1  OR of pending

Behaviour:
- Reset, asynchronous: pending=0, wait=0, urgent=0, grant_valid=0, grant_idx=0, FSM=IDLE, last_served=NUM_CH-1 (so channel 0 wins the first tie). Synchroniser and debounce state are also cleared. Reset asserted mid-operation aborts any grant immediately.
- Input path, per channel:
  - 2-flop synchroniser.
  - Debounce counter counts consecutive synchronised-high cycles and resets to 0 on any low.
  - A press event is one cycle, emitted when the count reaches DEBOUNCE.
  - A new event requires a synchronised low first; there is no auto-repeat while held.
  - Latency: with input held high, pending[i] is visible after the (DEBOUNCE+2)th rising edge following the input rise.
- Pending:
  - Set by a press event; sticky.
  - Cleared by clear_in[i], by grant_done for the granted channel, or by reset.
  - clear_in has priority over a same-cycle press event.
  - If clear_in drops while the button is still held, pending stays 0 until release and re-press.
- Wait counter, per channel:
  - Increments every cycle while pending; saturates at 2^WAIT_W-1 (no wrap).
  - Forced to 0 in the cycle pending clears.
  - urgent is combinational from pending and wait.
- FSM IDLE:
  - If any_pending, pick a channel and go to GRANT.
  - grant_valid=1 and grant_idx are registered, appearing the cycle after selection.
  - Selection: if any urgent, round-robin among urgent channels; otherwise round-robin among pending. Search starts at last_served+1 modulo NUM_CH.
- FSM GRANT:
  - Hold grant_valid and grant_idx.
  - If grant_valid and grant_ready are both high, go to SERVE; grant_valid drops the next cycle.
  - If clear_in[grant_idx] is high (and ready is low), withdraw: grant_valid=0 and return to IDLE.
  - If ready and clear arrive in the same cycle, ready wins and the FSM goes to SERVE.
- FSM SERVE:
  - Wait for grant_done.
  - On grant_done, clear pending[grant_idx] and wait[grant_idx], set last_served=grant_idx, go to IDLE.
  - Press events on grant_idx while in SERVE are discarded (request is already being served).
  - Other channels latch normally throughout.
- grant_done outside SERVE is ignored.
- Minimum turnaround: IDLE->GRANT takes 1 cycle, so back-to-back grants are separated by at least one cycle with grant_valid=0.

Decomposition:
- Package walk_pkg:
  - FSM state enum {IDLE, GRANT, SERVE}
  - Default constants for NUM_CH, DEBOUNCE, WAIT_W, URGENT_LIMIT
  - Index-width helper (clog2 of NUM_CH)
- Sub-module walk_debounce: synchroniser, debounce counter and one-shot for one channel, with parameter DEBOUNCE. Instantiated NUM_CH times in a generate loop.
- Round-robin pick is a function in the top module.

Test Plan:
1. sys_reset=1 for 2 cycles with walk_req_in=4'b1111 held -> all outputs 0 and grant_valid=0. Raise sys_reset during SERVE of channel 2 -> grant_valid=0, pending=0 asynchronously.
2. DEBOUNCE=3: a 2-cycle pulse on walk_req_in[1] -> pending[1] stays 0. Hold for 6 cycles -> pending[1]=1 after the 5th edge, with exactly one event.
3. clear_in[0]=1 while pressing button 0 -> pending[0]=0. Drop clear with button still held -> pending[0] stays 0. Release and re-press for 3 or more cycles -> pending[0]=1.
4. Press 0, 2 and 3 together, with grant_ready=1 and grant_done 4 cycles after each grant -> grant_idx sequence 0, 2, 3; pending ends at 0000 and any_pending=0.
5. URGENT_LIMIT=10: channel 1 is served for 20 cycles while channels 3 and 0 are pending (3 pending first) -> urgent=4'b1001 and the next grant follows urgent round-robin from last_served=1, i.e. 3. A wait counter with WAIT_W=4 saturates at 15.
6. Channel 2 is in GRANT with grant_ready=0 and clear_in[2] pulses -> grant_valid drops the next cycle, FSM returns to IDLE, and the next pending channel is granted. Same-cycle ready+clear -> FSM enters SERVE.
